bcd_conv_scheduler: RTL and testbench
=====================================

# bcd_conv_scheduler

Time-shares one combinational binary-to-BCD converter (5-bit even-value code in, 6-bit BCD {BCD40,BCD20,BCD10,BCD8,BCD4,BCD2} out, active-high disable EO forcing all-ones) among NREQ requesters. Round-robin arbitration grants one request at a time. The block drives the converter's inputs and holds EO low only while a conversion is in flight. It samples the result after a programmable settle time and returns it with the requester ID over a valid/ready response port.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- SETTLE, 1, converter settle cycles, i.e. the number of DRIVE cycles; legal range 1..15.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i set: requester i has a code pending
- req_code  in  5*NREQ  requester i code at [5i+4:5i] = {Bin32,Bin16,Bin8,Bin4,Bin2}
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  3  index of the served requester
- rsp_bcd  out  6  captured {BCD40,BCD20,BCD10,BCD8,BCD4,BCD2}
- cv_bin  out  5  to converter {Bin32..Bin2}
- cv_eo  out  1  to converter EO; 1 = disabled
- cv_bcd  in  6  from converter
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky converter-error flag

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - cv_eo = 1.
  - If any req_valid bit is set, req_ready is asserted combinationally for the winner: the first set bit searching from (ptr+1) mod NREQ upward with wrap-around.
  - On the clock edge: latch code into cv_bin and the winner index into rsp_id; ptr ← winner; load settle counter with SETTLE-1; go to DRIVE.
  - With no requests: req_ready = 0 and the FSM stays in IDLE.
- DRIVE:
  - cv_eo = 0; cv_bin is held.
  - Counter decrements each cycle. On the edge where the counter is 0: rsp_bcd ← cv_bcd; go to RESP.
  - If the sampled cv_bcd = 6'b111111: err ← 1. This value never appears in valid BCD output. The response is still delivered.
- RESP:
  - cv_eo = 1; rsp_valid = 1.
  - rsp_id and rsp_bcd are held stable until the rsp_valid & rsp_ready edge, then go to IDLE.
  - req_ready = 0 throughout.
- Requesters not granted keep req_valid high; no request is lost or reordered per requester.
- req_valid deasserted by a requester before it is granted: that requester is simply skipped.
- err is cleared only by reset.
- cv_bin is held after RESP until the next grant. Its value is don't-care while cv_eo = 1.

## Timing
- Reset (asynchronous, immediate) values:
  - state IDLE; ptr = NREQ-1, so requester 0 has first priority.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_bcd = 0, cv_bin = 0, cv_eo = 1, busy = 0, err = 0.
- Reset during DRIVE or RESP aborts the transaction with no response; cv_eo goes to 1 asynchronously.
- Handshake at cycle T leads to:
  - DRIVE in cycles T+1 .. T+SETTLE.
  - rsp_valid high from cycle T+SETTLE+1.
  - Response accepted at cycle R leads to IDLE at R+1, where the next grant may occur.
- Peak throughput, with rsp_ready tied high: one conversion per SETTLE+2 cycles.
- cv_eo is low for exactly SETTLE cycles per conversion.
- cv_bin changes only on the grant edge, so it is stable for the entire time cv_eo = 0.
- req_ready depends combinationally on req_valid, but only in IDLE. There is no combinational path from rsp_ready to any output.

## Test plan
- Reset: assert reset mid-cycle → all outputs at the reset values listed above, asynchronously. After release with no requests: busy = 0 and cv_eo = 1 indefinitely.
- Single request, SETTLE = 1, converter model attached:
  - req_valid[2] = 1, code 5'b10011 → req_ready = 4'b0100 in cycle T.
  - cv_eo low only in T+1.
  - rsp_valid at T+2 with rsp_id = 2, rsp_bcd = 6'b011100 (38).
  - Repeat with code 5'b11111 → 6'b110001 (62) and code 5'b00000 → 6'b000000.
- Round-robin: all four req_valid held high after reset, rsp_ready = 1 → grant order 0,1,2,3,0,1. Each response carries the matching rsp_id, one every 3 cycles.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_id and rsp_bcd stay stable, req_ready stays 0 and cv_eo stays 1. Release → IDLE next cycle.
- Error: converter model forced to 6'b111111 during DRIVE → err = 1 and the response is still delivered with rsp_bcd = 6'b111111. err stays 1 through subsequent good conversions until reset.
- SETTLE = 4 and reset abort:
  - cv_eo low for exactly 4 cycles, with a mid-DRIVE cv_bcd glitch ignored (only the last-cycle value is captured).
  - Reset asserted in DRIVE → no rsp_valid.
  - After reset, requester 0 is granted first.

Source files
------------

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler that time-shares one external binary-to-BCD converter among
// NREQ requesters and returns each sampled result with the requester ID.
module bcd_conv_scheduler #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [5*NREQ-1:0] req_code,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2:0]        rsp_id,
    output logic [5:0]        rsp_bcd,
    output logic [4:0]        cv_bin,
    output logic              cv_eo,
    input  logic [5:0]        cv_bcd,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] winner;
    logic       found;
    logic [3:0] cnt;

    // Search starts just past the last winner so every requester gets a turn.
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = 3'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = DRIVE;
            DRIVE:   if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The converter is enabled only during DRIVE; cv_eo follows the async reset.
    always_comb begin
        req_ready = '0;
        cv_eo     = 1'b1;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        if (state == IDLE && found) req_ready = NREQ'(1) << winner;
        if (state == DRIVE) cv_eo = 1'b0;
        if (state == RESP) rsp_valid = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= 3'(NREQ - 1);
            cnt     <= '0;
            cv_bin  <= '0;
            rsp_id  <= '0;
            rsp_bcd <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cv_bin <= req_code[int'(winner)*5 +: 5];
                        rsp_id <= winner;
                        ptr    <= winner;
                        cnt    <= 4'(SETTLE - 1);
                    end
                end
                DRIVE: begin
                    if (cnt == 4'd0) begin
                        rsp_bcd <= cv_bcd;
                        // All-ones is never a legal BCD result, so it marks a converter fault.
                        if (&cv_bcd) err <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: two instances (SETTLE=1 and SETTLE=4), each with a
// converter model, checked every cycle against a transaction-level reference.
module tb_bcd_conv_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Value 2*code as tens digit {40,20,10} and even units digit {8,4,2}.
    function automatic logic [5:0] bcd_ref(input logic [4:0] code);
        int v;
        v = 2 * int'(code);
        return {3'(v / 10), 3'((v % 10) / 2)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instance a: SETTLE = 1
    logic [N-1:0]   ra_valid, ra_ready;
    logic [5*N-1:0] ra_code;
    logic           ra_rsp_valid, ra_rsp_ready, ra_eo, ra_busy, ra_err;
    logic [2:0]     ra_id;
    logic [5:0]     ra_bcd, ra_cvbcd;
    logic [4:0]     ra_bin;
    logic           fa_err, fa_glitch;
    logic [5:0]     fa_gval;

    // Instance b: SETTLE = 4
    logic [N-1:0]   rb_valid, rb_ready;
    logic [5*N-1:0] rb_code;
    logic           rb_rsp_valid, rb_rsp_ready, rb_eo, rb_busy, rb_err;
    logic [2:0]     rb_id;
    logic [5:0]     rb_bcd, rb_cvbcd;
    logic [4:0]     rb_bin;
    logic           fb_err, fb_glitch;
    logic [5:0]     fb_gval;

    assign ra_cvbcd = (ra_eo || fa_err) ? 6'h3F : (fa_glitch ? fa_gval : bcd_ref(ra_bin));
    assign rb_cvbcd = (rb_eo || fb_err) ? 6'h3F : (fb_glitch ? fb_gval : bcd_ref(rb_bin));

    bcd_conv_scheduler #(.NREQ(N), .SETTLE(1)) dut_a (
        .clk(clk), .reset(reset), .req_valid(ra_valid), .req_code(ra_code),
        .req_ready(ra_ready), .rsp_valid(ra_rsp_valid), .rsp_ready(ra_rsp_ready),
        .rsp_id(ra_id), .rsp_bcd(ra_bcd), .cv_bin(ra_bin), .cv_eo(ra_eo),
        .cv_bcd(ra_cvbcd), .busy(ra_busy), .err(ra_err)
    );

    bcd_conv_scheduler #(.NREQ(N), .SETTLE(4)) dut_b (
        .clk(clk), .reset(reset), .req_valid(rb_valid), .req_code(rb_code),
        .req_ready(rb_ready), .rsp_valid(rb_rsp_valid), .rsp_ready(rb_rsp_ready),
        .rsp_id(rb_id), .rsp_bcd(rb_bcd), .cv_bin(rb_bin), .cv_eo(rb_eo),
        .cv_bcd(rb_cvbcd), .busy(rb_busy), .err(rb_err)
    );

    // Reference: mt = -1 when idle, else cycles since the grant cycle.
    int         mt[2];
    int         mptr[2];
    int         mid[2];
    logic [4:0] mcode[2];
    logic [5:0] mexp[2];
    logic       merr[2];
    int         glog[$];
    int         gcyc[$];

    task automatic step(input int m, input int s, input logic [3:0] rv, input logic [19:0] rc,
                        input logic [3:0] rr, input logic rspv, input logic rsprdy,
                        input logic [2:0] id, input logic [5:0] bcd, input logic [4:0] bin,
                        input logic eo, input logic bsy, input logic er,
                        input logic force_e, input logic glitch, input logic [5:0] gval);
        string p;
        int    w;
        p = (m == 0) ? "s1" : "s4";
        check({p, ".err"}, 32'(er), 32'(merr[m]));
        if (mt[m] < 0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && rv[(mptr[m] + k) % N]) w = (mptr[m] + k) % N;
            check({p, ".req_ready"}, 32'(rr), (w < 0) ? 32'd0 : (32'd1 << w));
            check({p, ".idle_busy"}, 32'(bsy), 32'd0);
            check({p, ".idle_eo"}, 32'(eo), 32'd1);
            check({p, ".idle_rsp_valid"}, 32'(rspv), 32'd0);
            if (w >= 0) begin
                mid[m]   = w;
                mcode[m] = rc[w*5 +: 5];
                mptr[m]  = w;
                mt[m]    = 1;
                if (m == 0) begin
                    glog.push_back(w);
                    gcyc.push_back(cyc);
                end
            end
        end else if (mt[m] <= s) begin
            check({p, ".drive_eo"}, 32'(eo), 32'd0);
            check({p, ".drive_busy"}, 32'(bsy), 32'd1);
            check({p, ".drive_rsp_valid"}, 32'(rspv), 32'd0);
            check({p, ".drive_req_ready"}, 32'(rr), 32'd0);
            check({p, ".drive_cv_bin"}, 32'(bin), 32'(mcode[m]));
            if (mt[m] == s) begin
                mexp[m] = force_e ? 6'h3F : (glitch ? gval : bcd_ref(mcode[m]));
                if (mexp[m] == 6'h3F) merr[m] = 1'b1;
            end
            mt[m]++;
        end else begin
            check({p, ".resp_valid"}, 32'(rspv), 32'd1);
            check({p, ".resp_id"}, 32'(id), 32'(mid[m]));
            check({p, ".resp_bcd"}, 32'(bcd), 32'(mexp[m]));
            check({p, ".resp_eo"}, 32'(eo), 32'd1);
            check({p, ".resp_req_ready"}, 32'(rr), 32'd0);
            check({p, ".resp_busy"}, 32'(bsy), 32'd1);
            if (rsprdy) mt[m] = -1;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                mt[m]   = -1;
                mptr[m] = N - 1;
                merr[m] = 1'b0;
            end
        end else begin
            step(0, 1, ra_valid, ra_code, ra_ready, ra_rsp_valid, ra_rsp_ready, ra_id, ra_bcd,
                 ra_bin, ra_eo, ra_busy, ra_err, fa_err, fa_glitch, fa_gval);
            step(1, 4, rb_valid, rb_code, rb_ready, rb_rsp_valid, rb_rsp_ready, rb_id, rb_bcd,
                 rb_bin, rb_eo, rb_busy, rb_err, fb_err, fb_glitch, fb_gval);
        end
    end

    task automatic reset_check();
        check("rst.a_req_ready", 32'(ra_ready), 32'd0);
        check("rst.a_rsp_valid", 32'(ra_rsp_valid), 32'd0);
        check("rst.a_rsp_id", 32'(ra_id), 32'd0);
        check("rst.a_rsp_bcd", 32'(ra_bcd), 32'd0);
        check("rst.a_cv_bin", 32'(ra_bin), 32'd0);
        check("rst.a_cv_eo", 32'(ra_eo), 32'd1);
        check("rst.a_busy", 32'(ra_busy), 32'd0);
        check("rst.a_err", 32'(ra_err), 32'd0);
        check("rst.b_rsp_valid", 32'(rb_rsp_valid), 32'd0);
        check("rst.b_rsp_bcd", 32'(rb_bcd), 32'd0);
        check("rst.b_cv_eo", 32'(rb_eo), 32'd1);
        check("rst.b_busy", 32'(rb_busy), 32'd0);
        check("rst.b_err", 32'(rb_err), 32'd0);
    endtask

    // Called at posedge+1; asserts reset mid-cycle and returns at posedge+1.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 reset_check();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Requester 2 on instance a with rsp_ready high; returns at posedge+1 in IDLE.
    task automatic single_a(input logic [4:0] code, input logic [5:0] exp_bcd, input string nm);
        ra_code[14:10] = code;
        ra_valid       = 4'b0100;
        ra_rsp_ready   = 1'b1;
        @(negedge clk);
        check({nm, ".grant"}, 32'(ra_ready), 32'h4);
        @(posedge clk);
        #1 ra_valid = '0;
        @(negedge clk);
        check({nm, ".eo_low"}, 32'(ra_eo), 32'd0);
        @(negedge clk);
        check({nm, ".rsp_valid"}, 32'(ra_rsp_valid), 32'd1);
        check({nm, ".rsp_id"}, 32'(ra_id), 32'd2);
        check({nm, ".rsp_bcd"}, 32'(ra_bcd), 32'(exp_bcd));
        check({nm, ".eo_high"}, 32'(ra_eo), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ga;
        logic [3:0] gb;
        int         low;
        int         seen;
        ra_valid = '0; ra_code = '0; ra_rsp_ready = 1'b1;
        rb_valid = '0; rb_code = '0; rb_rsp_ready = 1'b1;
        fa_err = 1'b0; fa_glitch = 1'b0; fa_gval = '0;
        fb_err = 1'b0; fb_glitch = 1'b0; fb_gval = '0;

        check("ref.38", 32'(bcd_ref(5'b10011)), 32'h1C);
        check("ref.62", 32'(bcd_ref(5'b11111)), 32'h31);
        check("ref.0", 32'(bcd_ref(5'b00000)), 32'h00);

        @(posedge clk);
        #1 pulse_reset();
        repeat (5) @(posedge clk);
        #1;

        single_a(5'b10011, 6'b011100, "single38");
        single_a(5'b11111, 6'b110001, "single62");
        single_a(5'b00000, 6'b000000, "single0");

        // Round-robin with all requesters held high.
        pulse_reset();
        glog.delete();
        gcyc.delete();
        ra_code  = {5'd4, 5'd3, 5'd2, 5'd1};
        ra_valid = 4'hF;
        repeat (18) @(posedge clk);
        #1 ra_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rr.count_ok", 32'(glog.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < glog.size()) check("rr.order", 32'(glog[i]), 32'(i % 4));
            if (i > 0 && i < gcyc.size()) check("rr.spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end

        // Backpressure on requester 1, others waiting.
        ra_rsp_ready = 1'b0;
        ra_code[9:5]   = 5'b00101;
        ra_code[19:15] = 5'b01001;
        ra_valid       = 4'b0010;
        @(negedge clk);
        check("bp.grant", 32'(ra_ready), 32'h2);
        @(posedge clk);
        #1 ra_valid = 4'b1001;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.rsp_valid", 32'(ra_rsp_valid), 32'd1);
            check("bp.rsp_id", 32'(ra_id), 32'd1);
            check("bp.rsp_bcd", 32'(ra_bcd), 32'h08);
            check("bp.req_ready", 32'(ra_ready), 32'd0);
            check("bp.eo", 32'(ra_eo), 32'd1);
        end
        @(posedge clk);
        #1 ra_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp.idle_busy", 32'(ra_busy), 32'd0);
        check("bp.next_grant", 32'(ra_ready), 32'h8);
        @(posedge clk);
        #1 ra_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Converter fault: err is sticky until reset.
        fa_err = 1'b1;
        single_a(5'b00111, 6'h3F, "errconv");
        fa_err = 1'b0;
        check("err.set", 32'(ra_err), 32'd1);
        single_a(5'b10011, 6'b011100, "errgood");
        check("err.sticky", 32'(ra_err), 32'd1);
        pulse_reset();
        check("err.cleared", 32'(ra_err), 32'd0);

        // SETTLE=4: eo low for four cycles, early glitch ignored.
        rb_code[4:0] = 5'b01010;
        rb_valid     = 4'b0001;
        @(negedge clk);
        check("s4.grant", 32'(rb_ready), 32'h1);
        @(posedge clk);
        #1 rb_valid = '0;
        fb_glitch = 1'b1;
        fb_gval   = 6'b101010;
        low = 0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            if (!rb_eo) low++;
            if (j == 5) begin
                check("s4.rsp_valid", 32'(rb_rsp_valid), 32'd1);
                check("s4.rsp_bcd", 32'(rb_bcd), 32'h10);
            end
            @(posedge clk);
            #1 if (j == 2) fb_glitch = 1'b0;
        end
        check("s4.eo_low_cycles", 32'(low), 32'd4);

        // Reset mid-DRIVE aborts without a response.
        rb_code[9:5] = 5'b11000;
        rb_valid     = 4'b0010;
        @(posedge clk);
        #1 rb_valid = '0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort.eo", 32'(rb_eo), 32'd1);
        check("abort.rsp_valid", 32'(rb_rsp_valid), 32'd0);
        check("abort.busy", 32'(rb_busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rb_rsp_valid) seen++;
        end
        check("abort.no_rsp", 32'(seen), 32'd0);
        @(posedge clk);
        #1 rb_valid = 4'hF;
        @(negedge clk);
        check("abort.first_grant", 32'(rb_ready), 32'h1);
        @(posedge clk);
        #1 rb_valid = '0;
        repeat (8) @(posedge clk);
        #1;

        // Randomized traffic on both instances.
        repeat (3000) begin
            @(negedge clk);
            ga = ra_valid & ra_ready;
            gb = rb_valid & rb_ready;
            @(posedge clk);
            #1;
            ra_valid = ra_valid & ~ga;
            rb_valid = rb_valid & ~gb;
            for (int i = 0; i < N; i++) begin
                if (!ra_valid[i] && $urandom_range(0, 2) == 0) begin
                    ra_valid[i] = 1'b1;
                    ra_code[i*5 +: 5] = 5'($urandom);
                end else if (ra_valid[i] && $urandom_range(0, 63) == 0) begin
                    ra_valid[i] = 1'b0;
                end
                if (!rb_valid[i] && $urandom_range(0, 2) == 0) begin
                    rb_valid[i] = 1'b1;
                    rb_code[i*5 +: 5] = 5'($urandom);
                end else if (rb_valid[i] && $urandom_range(0, 63) == 0) begin
                    rb_valid[i] = 1'b0;
                end
            end
            ra_rsp_ready = ($urandom_range(0, 3) != 0);
            rb_rsp_ready = ($urandom_range(0, 3) != 0);
            fa_err    = ($urandom_range(0, 31) == 0);
            fb_err    = ($urandom_range(0, 31) == 0);
            fa_glitch = ($urandom_range(0, 3) == 0);
            fb_glitch = ($urandom_range(0, 3) == 0);
            fa_gval   = 6'($urandom);
            fb_gval   = 6'($urandom);
        end

        ra_valid = '0; rb_valid = '0;
        ra_rsp_ready = 1'b1; rb_rsp_ready = 1'b1;
        fa_err = 1'b0; fb_err = 1'b0; fa_glitch = 1'b0; fb_glitch = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
